// File: rtl/sti_unpack.sv
// Unpacks a 1024x16-bit bit-plane ROM into a 128x128 byte-per-pixel result RAM.
// Optional STI_UNPACK_BORDER_CLR_EN forces the one-pixel image border to background.
module sti_unpack #(
  parameter logic [7:0] ONE_VAL  = 8'h01,
  parameter logic [7:0] ZERO_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        sti_rd,
  output logic [9:0]  sti_addr,
  input  logic [15:0] sti_di,
  output logic        res_wr,
  output logic [13:0] res_addr,
  output logic [7:0]  res_do,
  output logic [14:0] obj_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [14:0] CNT_MAX = 15'd16384;

  logic [1:0]  state_q, state_d;
  logic [9:0]  word_q, word_d;
  logic [3:0]  k_q, k_d;
  logic [15:0] shreg_q, shreg_d;
  logic [14:0] obj_cnt_q, obj_cnt_d;

  logic [13:0] pix_idx;
  logic        last_pix, last_word, border, pix_one;

  assign pix_idx   = {word_q, k_q};
  assign last_pix  = (k_q == 4'd15);
  assign last_word = (word_q == 10'd1023);

`ifdef STI_UNPACK_BORDER_CLR_EN
  assign border = (pix_idx[13:7] == 7'd0) || (pix_idx[13:7] == 7'd127) ||
                  (pix_idx[6:0] == 7'd0)  || (pix_idx[6:0] == 7'd127);
`else
  assign border = 1'b0;
`endif

  // Shift register MSB is always the current pixel (leftmost first).
  assign pix_one = shreg_q[15] & ~border;

  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    res_wr   = (state_q == S_WRITE);
    sti_rd   = 1'b0;
    sti_addr = 10'd0;
    res_addr = 14'd0;
    res_do   = 8'd0;
    obj_cnt  = obj_cnt_q;
    if (state_q == S_FETCH) begin
      sti_rd   = 1'b1;
      sti_addr = word_q;
    end
    if (state_q == S_WRITE) begin
      res_addr = pix_idx;
      res_do   = pix_one ? ONE_VAL : ZERO_VAL;
      // Prefetch the next word during the last pixel so writes stay back-to-back.
      if (last_pix && !last_word) begin
        sti_rd   = 1'b1;
        sti_addr = word_q + 10'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    k_d       = k_q;
    shreg_d   = shreg_q;
    obj_cnt_d = obj_cnt_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_FETCH;
        word_d    = 10'd0;
        k_d       = 4'd0;
        obj_cnt_d = 15'd0;
      end
      S_FETCH: begin
        state_d = S_WRITE;
        shreg_d = sti_di;
        k_d     = 4'd0;
      end
      S_WRITE: begin
        k_d     = k_q + 4'd1;
        shreg_d = {shreg_q[14:0], 1'b0};
        if (pix_one && obj_cnt_q != CNT_MAX) obj_cnt_d = obj_cnt_q + 15'd1;
        if (last_pix) begin
          if (last_word) state_d = S_DONE;
          else begin
            shreg_d = sti_di;
            word_d  = word_q + 10'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      word_q    <= 10'd0;
      k_q       <= 4'd0;
      shreg_q   <= 16'd0;
      obj_cnt_q <= 15'd0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      k_q       <= k_d;
      shreg_q   <= shreg_d;
      obj_cnt_q <= obj_cnt_d;
    end
  end

endmodule
